// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode encoding, MEM-stage FSM states and byte-lane helpers.
package lc3b_types;

    typedef enum logic [3:0] {
        OpBr   = 4'b0000,
        OpAdd  = 4'b0001,
        OpLdb  = 4'b0010,
        OpStb  = 4'b0011,
        OpJsr  = 4'b0100,
        OpAnd  = 4'b0101,
        OpLdr  = 4'b0110,
        OpStr  = 4'b0111,
        OpRti  = 4'b1000,
        OpNot  = 4'b1001,
        OpLdi  = 4'b1010,
        OpSti  = 4'b1011,
        OpJmp  = 4'b1100,
        OpShf  = 4'b1101,
        OpLea  = 4'b1110,
        OpTrap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPtr  = 2'b01,
        StData = 2'b10
    } mem_state_t;

    localparam int unsigned BYTE_W = 8;

    // Lane-index width, kept at least 1 so a single-lane bus still has a legal slice.
    function automatic int unsigned lane_bits(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic logic is_plain_op(input lc3b_opcode op);
        return (op == OpLdr) || (op == OpLdb) || (op == OpStr) || (op == OpStb) || (op == OpTrap);
    endfunction

    function automatic logic is_ind_op(input lc3b_opcode op);
        return (op == OpLdi) || (op == OpSti);
    endfunction

    function automatic logic is_store_op(input lc3b_opcode op);
        return (op == OpStr) || (op == OpStb) || (op == OpSti);
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for the data bus: lane enables and byte-store data replication.
module mem_lane_steer
    import lc3b_types::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LANE_BITS = 1
) (
    input  logic                     byte_mode,
    input  logic [LANE_BITS-1:0]     lane_addr,
    input  logic [DATA_W-1:0]        store_data,
    output logic [DATA_W/BYTE_W-1:0] sel,
    output logic [DATA_W-1:0]        wdata
);

    localparam int unsigned LANES = DATA_W / BYTE_W;

    always_comb begin
        sel   = '1;
        wdata = store_data;
        if (byte_mode) begin
            sel            = '0;
            sel[lane_addr] = 1'b1;
            wdata          = {LANES{store_data[BYTE_W-1:0]}};
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage bus controller: plain and indirect (LDI/STI) accesses with pipeline stall.
// Optional per-request wait timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_ex_mem,
    input  lc3b_opcode               opcode,
    input  logic [ADDR_W-1:0]        alu_out,
    input  logic [DATA_W-1:0]        dest_out,
    input  logic                     dmem_resp,
    input  logic [DATA_W-1:0]        dmem_rdata,
    output logic                     dmem_cyc,
    output logic                     dmem_stb,
    output logic                     dmem_we,
    output logic [DATA_W/BYTE_W-1:0] dmem_sel,
    output logic [ADDR_W-1:0]        dmem_addr,
    output logic [DATA_W-1:0]        dmem_wdata,
    output logic                     mem_stall,
    output logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_err
);

    localparam int unsigned LANES     = DATA_W / BYTE_W;
    localparam int unsigned LANE_BITS = lane_bits(LANES);

    mem_state_t        state_q;
    lc3b_opcode        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ptr_q;

    logic       idle;
    logic       start_plain;
    logic       start_ind;
    logic       start;
    logic       data_phase;
    logic       final_resp;
    logic       byte_mode;
    logic       tmo_hit;
    lc3b_opcode cur_op;

    // rst_n gates the IDLE launch so the bus is quiet for the whole reset window.
    assign idle        = (state_q == StIdle);
    assign start_plain = idle && rst_n && load_ex_mem && is_plain_op(opcode);
    assign start_ind   = idle && rst_n && load_ex_mem && is_ind_op(opcode);
    assign start       = start_plain || start_ind;
    assign cur_op      = idle ? opcode : op_q;
    assign data_phase  = start_plain || (state_q == StData);
    assign final_resp  = (state_q == StData) && dmem_resp;
    assign byte_mode   = data_phase && (cur_op == OpStb);

    assign dmem_cyc  = !idle || start;
    assign dmem_stb  = dmem_cyc;
    assign dmem_we   = data_phase && is_store_op(cur_op);
    assign mem_stall = dmem_cyc && !final_resp;

    always_comb begin
        dmem_addr = alu_out;
        unique case (state_q)
            StPtr:   dmem_addr = addr_q;
            StData:  dmem_addr = is_ind_op(op_q) ? ptr_q : addr_q;
            default: dmem_addr = alu_out;
        endcase
    end

    mem_lane_steer #(
        .DATA_W    (DATA_W),
        .LANE_BITS (LANE_BITS)
    ) u_lane_steer (
        .byte_mode  (byte_mode),
        .lane_addr  (dmem_addr[LANE_BITS-1:0]),
        .store_data (dest_out),
        .sel        (dmem_sel),
        .wdata      (dmem_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpBr;
            addr_q    <= '0;
            ptr_q     <= '0;
            mem_rdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= opcode;
                        addr_q  <= alu_out;
                        state_q <= start_ind ? StPtr : StData;
                    end
                end
                StPtr: begin
                    if (tmo_hit) begin
                        state_q <= StIdle;
                    end else if (dmem_resp) begin
                        ptr_q   <= ADDR_W'(dmem_rdata);
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (tmo_hit) begin
                        state_q <= StIdle;
                    end else if (dmem_resp) begin
                        if (!is_store_op(op_q)) begin
                            mem_rdata <= dmem_rdata;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;

    // Fires on the last allowed wait cycle; the abort and error pulse land on the next edge.
    assign tmo_hit = !idle && !dmem_resp && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= tmo_hit;
            if (idle || dmem_resp || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (DATA_W=16, ADDR_W=16, TIMEOUT_CYC=4).
module tb_mem_access_ctrl;
    import lc3b_types::*;

    logic        clk;
    logic        rst_n;
    logic        load_ex_mem;
    lc3b_opcode  opcode;
    logic [15:0] alu_out;
    logic [15:0] dest_out;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_cyc;
    logic        dmem_stb;
    logic        dmem_we;
    logic [1:0]  dmem_sel;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        mem_stall;
    logic [15:0] mem_rdata;
    logic        mem_err;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_ex_mem (load_ex_mem),
        .opcode      (opcode),
        .alu_out     (alu_out),
        .dest_out    (dest_out),
        .dmem_resp   (dmem_resp),
        .dmem_rdata  (dmem_rdata),
        .dmem_cyc    (dmem_cyc),
        .dmem_stb    (dmem_stb),
        .dmem_we     (dmem_we),
        .dmem_sel    (dmem_sel),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .mem_stall   (mem_stall),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic issue(input lc3b_opcode op, input logic [15:0] addr, input logic [15:0] data);
        next_cycle();
        load_ex_mem = 1'b1;
        opcode      = op;
        alu_out     = addr;
        dest_out    = data;
        dmem_resp   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_ex_mem = 1'b0; opcode = OpAdd; alu_out = '0; dest_out = '0;
        dmem_resp = 1'b0; dmem_rdata = '0;
        next_cycle(); next_cycle(); #1;
        n_cmp++;
        if ({dmem_cyc, dmem_stb, dmem_we, mem_stall, mem_err, mem_rdata} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got cyc=%b stb=%b we=%b stall=%b err=%b rdata=%h want all 0",
                     dmem_cyc, dmem_stb, dmem_we, mem_stall, mem_err, mem_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got cyc=%b stall=%b want 0 0", dmem_cyc, mem_stall);
        end
    endtask

    task automatic test_ldr();
        int stalls = 0;
        issue(OpLdr, 16'h3000, 16'h0000);
        n_cmp++;
        if ({dmem_cyc, dmem_stb, dmem_we, dmem_sel, dmem_addr} !== {1'b1, 1'b1, 1'b0, 2'b11, 16'h3000}) begin
            n_fail++;
            $display("FAIL ldr_issue: got cyc=%b stb=%b we=%b sel=%b addr=%h want 1 1 0 11 3000",
                     dmem_cyc, dmem_stb, dmem_we, dmem_sel, dmem_addr);
        end
        stalls += int'(mem_stall);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            load_ex_mem = 1'b0;
            #1;
            stalls += int'(mem_stall);
        end
        next_cycle();
        dmem_resp = 1'b1; dmem_rdata = 16'hBEEF;
        #1;
        stalls += int'(mem_stall);
        n_cmp++;
        if (stalls !== 3) begin
            n_fail++;
            $display("FAIL ldr_stall_count: got %0d want 3", stalls);
        end
        n_cmp++;
        if ({dmem_cyc, mem_stall, dmem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL ldr_resp_cycle: got cyc=%b stall=%b we=%b want 1 0 0", dmem_cyc, mem_stall, dmem_we);
        end
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_rdata} !== {1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL ldr_result: got cyc=%b rdata=%h want 0 beef", dmem_cyc, mem_rdata);
        end
    endtask

    task automatic test_stb();
        issue(OpStb, 16'h3001, 16'h12AB);
        n_cmp++;
        if ({dmem_cyc, dmem_we, dmem_sel, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, 2'b10, 16'hABAB, 16'h3001}) begin
            n_fail++;
            $display("FAIL stb_issue: got cyc=%b we=%b sel=%b wdata=%h addr=%h want 1 1 10 abab 3001",
                     dmem_cyc, dmem_we, dmem_sel, dmem_wdata, dmem_addr);
        end
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1;
        #1;
        n_cmp++;
        if ({mem_stall, dmem_we, dmem_sel, dmem_wdata} !== {1'b0, 1'b1, 2'b10, 16'hABAB}) begin
            n_fail++;
            $display("FAIL stb_resp: got stall=%b we=%b sel=%b wdata=%h want 0 1 10 abab",
                     mem_stall, dmem_we, dmem_sel, dmem_wdata);
        end
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_rdata} !== {1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL stb_single_req: got cyc=%b rdata=%h want 0 beef", dmem_cyc, mem_rdata);
        end
    endtask

    task automatic test_ldi();
        int stalls = 0;
        int reqs   = 0;
        issue(OpLdi, 16'h4000, 16'h0000);
        n_cmp++;
        if ({dmem_cyc, dmem_we, dmem_addr} !== {1'b1, 1'b0, 16'h4000}) begin
            n_fail++;
            $display("FAIL ldi_issue: got cyc=%b we=%b addr=%h want 1 0 4000", dmem_cyc, dmem_we, dmem_addr);
        end
        stalls += int'(mem_stall);
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h5000;
        #1;
        stalls += int'(mem_stall);
        reqs += int'(dmem_cyc && dmem_resp);
        n_cmp++;
        if ({dmem_addr, mem_stall, dmem_we} !== {16'h4000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ldi_ptr_resp: got addr=%h stall=%b we=%b want 4000 1 0", dmem_addr, mem_stall, dmem_we);
        end
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        stalls += int'(mem_stall);
        n_cmp++;
        if ({dmem_cyc, dmem_addr, dmem_we} !== {1'b1, 16'h5000, 1'b0}) begin
            n_fail++;
            $display("FAIL ldi_data_addr: got cyc=%b addr=%h we=%b want 1 5000 0", dmem_cyc, dmem_addr, dmem_we);
        end
        next_cycle();
        dmem_resp = 1'b1; dmem_rdata = 16'h00C3;
        #1;
        reqs += int'(dmem_cyc && dmem_resp);
        n_cmp++;
        if ({stalls, mem_stall} !== {32'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL ldi_stall: got stalls=%0d final_stall=%b want 3 0", stalls, mem_stall);
        end
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        n_cmp++;
        if ({reqs, dmem_cyc, mem_rdata} !== {32'd2, 1'b0, 16'h00C3}) begin
            n_fail++;
            $display("FAIL ldi_result: got reqs=%0d cyc=%b rdata=%h want 2 0 00c3", reqs, dmem_cyc, mem_rdata);
        end
    endtask

    task automatic test_sti();
        issue(OpSti, 16'h6000, 16'h55AA);
        n_cmp++;
        if ({dmem_we, dmem_addr} !== {1'b0, 16'h6000}) begin
            n_fail++;
            $display("FAIL sti_ptr_req: got we=%b addr=%h want 0 6000", dmem_we, dmem_addr);
        end
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h6002;
        #1;
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        n_cmp++;
        if ({dmem_addr, dmem_we, dmem_sel, dmem_wdata, mem_stall} !== {16'h6002, 1'b1, 2'b11, 16'h55AA, 1'b1}) begin
            n_fail++;
            $display("FAIL sti_data_req: got addr=%h we=%b sel=%b wdata=%h stall=%b want 6002 1 11 55aa 1",
                     dmem_addr, dmem_we, dmem_sel, dmem_wdata, mem_stall);
        end
        next_cycle();
        dmem_resp = 1'b1;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_rdata} !== {1'b0, 16'h00C3}) begin
            n_fail++;
            $display("FAIL sti_done: got cyc=%b rdata=%h want 0 00c3", dmem_cyc, mem_rdata);
        end
    endtask

    task automatic test_back_to_back();
        issue(OpLdr, 16'h1000, 16'h0000);
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h1111;
        #1;
        issue(OpStr, 16'h2000, 16'h2222);
        n_cmp++;
        if ({dmem_cyc, dmem_we, dmem_addr, dmem_wdata, mem_rdata} !==
            {1'b1, 1'b1, 16'h2000, 16'h2222, 16'h1111}) begin
            n_fail++;
            $display("FAIL b2b_second_issue: got cyc=%b we=%b addr=%h wdata=%h rdata=%h want 1 1 2000 2222 1111",
                     dmem_cyc, dmem_we, dmem_addr, dmem_wdata, mem_rdata);
        end
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_rdata} !== {1'b0, 16'h1111}) begin
            n_fail++;
            $display("FAIL b2b_done: got cyc=%b rdata=%h want 0 1111", dmem_cyc, mem_rdata);
        end
    endtask

    task automatic test_stray_and_ignore();
        next_cycle();
        dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_stall, mem_rdata} !== {1'b0, 1'b0, 16'h1111}) begin
            n_fail++;
            $display("FAIL stray_resp: got cyc=%b stall=%b rdata=%h want 0 0 1111", dmem_cyc, mem_stall, mem_rdata);
        end
        issue(OpLdr, 16'h0200, 16'h0000);
        next_cycle();
        opcode = OpSti; alu_out = 16'h0999;
        #1;
        n_cmp++;
        if ({dmem_addr, dmem_we, mem_stall} !== {16'h0200, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ignore_load: got addr=%h we=%b stall=%b want 0200 0 1", dmem_addr, dmem_we, mem_stall);
        end
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h0A0A;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_rdata} !== {1'b0, 16'h0A0A}) begin
            n_fail++;
            $display("FAIL ignore_load_done: got cyc=%b rdata=%h want 0 0a0a", dmem_cyc, mem_rdata);
        end
    endtask

    task automatic test_reset_mid_ptr();
        issue(OpLdi, 16'h7000, 16'h0000);
        next_cycle();
        load_ex_mem = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, dmem_addr} !== {1'b1, 16'h7000}) begin
            n_fail++;
            $display("FAIL rst_ptr_pending: got cyc=%b addr=%h want 1 7000", dmem_cyc, dmem_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_cyc, dmem_stb, dmem_we, mem_stall, mem_rdata} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_mid_ptr: got cyc=%b stb=%b we=%b stall=%b rdata=%h want all 0",
                     dmem_cyc, dmem_stb, dmem_we, mem_stall, mem_rdata);
        end
        next_cycle();
        rst_n = 1'b1; dmem_resp = 1'b1; dmem_rdata = 16'h7777;
        #1;
        next_cycle();
        dmem_resp = 1'b0; dmem_rdata = '0;
        #1;
        n_cmp++;
        if ({dmem_cyc, mem_stall, mem_rdata} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_late_resp: got cyc=%b stall=%b rdata=%h want 0 0 0000", dmem_cyc, mem_stall, mem_rdata);
        end
        issue(OpLdr, 16'h0100, 16'h0000);
        n_cmp++;
        if (dmem_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL rst_new_req_addr: got %h want 0100", dmem_addr);
        end
        next_cycle();
        load_ex_mem = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h0123;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if (mem_rdata !== 16'h0123) begin
            n_fail++;
            $display("FAIL rst_new_req_data: got %h want 0123", mem_rdata);
        end
    endtask

    task automatic test_timeout();
        int bad_waits = 0;
        issue(OpLdr, 16'h0300, 16'h0000);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            load_ex_mem = 1'b0;
            #1;
            if (!mem_stall || mem_err) bad_waits++;
        end
        n_cmp++;
        if (bad_waits !== 0) begin
            n_fail++;
            $display("FAIL tmo_waits: got %0d bad wait cycles want 0", bad_waits);
        end
        next_cycle();
        #1;
        n_cmp++;
        if ({mem_err, mem_stall, dmem_cyc, mem_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0123}) begin
            n_fail++;
            $display("FAIL tmo_abort: got err=%b stall=%b cyc=%b rdata=%h want 1 0 0 0123",
                     mem_err, mem_stall, dmem_cyc, mem_rdata);
        end
        next_cycle();
        #1;
        n_cmp++;
        if ({mem_err, dmem_cyc} !== 2'b00) begin
            n_fail++;
            $display("FAIL tmo_pulse_width: got err=%b cyc=%b want 0 0", mem_err, dmem_cyc);
        end
`else
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            load_ex_mem = 1'b0;
            #1;
            if (!mem_stall || mem_err || !dmem_cyc) bad_waits++;
        end
        n_cmp++;
        if (bad_waits !== 0) begin
            n_fail++;
            $display("FAIL no_tmo_waits: got %0d bad wait cycles want 0", bad_waits);
        end
        next_cycle();
        dmem_resp = 1'b1; dmem_rdata = 16'h0333;
        #1;
        next_cycle();
        dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if ({mem_err, dmem_cyc, mem_rdata} !== {1'b0, 1'b0, 16'h0333}) begin
            n_fail++;
            $display("FAIL no_tmo_done: got err=%b cyc=%b rdata=%h want 0 0 0333", mem_err, dmem_cyc, mem_rdata);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_stb();
        test_ldi();
        test_sti();
        test_back_to_back();
        test_stray_and_ignore();
        test_reset_mid_ptr();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: data-bus and word width in bits, multiple of 8.
REQ-002 Parameter ADDR_W, default 16: dmem address width in bits.
REQ-003 Parameter TIMEOUT_CYC, default 64: wait-cycle limit per bus request (used only under MEM_TIMEOUT_EN).
REQ-004 Derived constant LANES = DATA_W/8: number of byte lanes.
REQ-005 Port list, one per line:
- clk  in  1  sole clock; one clock, all state on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load_ex_mem  in  1  new instruction enters MEM stage this cycle.
- opcode  in  lc3b_opcode  MEM-stage opcode.
- alu_out  in  ADDR_W  effective or pointer address.
- dest_out  in  DATA_W  store data.
- dmem_resp  in  1  bus acknowledge, one cycle per request.
- dmem_rdata  in  DATA_W  bus read data, valid with dmem_resp.
- dmem_cyc / dmem_stb  out  1  bus cycle and strobe.
- dmem_we  out  1  write strobe.
- dmem_sel  out  LANES  byte-lane enables.
- dmem_addr  out  ADDR_W  bus address.
- dmem_wdata  out  DATA_W  bus write data.
- mem_stall  out  1  hold the pipeline.
- mem_rdata  out  DATA_W  final load word.
- mem_err  out  1  one-cycle bus-timeout pulse.

Function
REQ-006 FSM states: IDLE, PTR, DATA; state register 2 bits, encoding in package.
REQ-007 IDLE, opcode in {LDR, LDB, STR, STB, TRAP} -> DATA, same cycle; request issued combinationally from alu_out.
REQ-008 IDLE, opcode in {LDI, STI} -> PTR; PTR reads the word at alu_out with dmem_we=0.
REQ-009 PTR, dmem_resp -> latch dmem_rdata into ptr_q; next state DATA; dmem_addr = ptr_q from the next cycle on.
REQ-010 DATA, dmem_resp -> IDLE.
REQ-011 dmem_cyc = dmem_stb = 1 in PTR and DATA, and in IDLE when REQ-007 or REQ-008 fires; otherwise 0.
REQ-012 mem_stall = dmem_cyc AND NOT (dmem_resp AND state/request is final DATA).
- Plain access: stall for wait cycles, release in the resp cycle.
- LDI/STI: stall through the PTR resp cycle.
REQ-013 dmem_we = 1 only in the DATA phase of STR, STB, STI.
REQ-014 dmem_sel: STB enables lane addr[log2(LANES)-1:0] only; all other accesses enable all lanes.
REQ-015 dmem_wdata: STB replicates dest_out[7:0] to every lane; otherwise dest_out.
REQ-016 mem_rdata registers dmem_rdata on DATA-phase resp of a load and holds until the next load completes.
REQ-017 dmem_resp in IDLE is ignored; dmem_resp with no request outstanding changes nothing.
REQ-018 load_ex_mem while state != IDLE is ignored; the FSM never aborts a started access.
REQ-019 Back-to-back accesses: resp in DATA with a new memory opcode presented the next cycle starts the new request from IDLE with no bubble beyond that cycle.

Reset
REQ-020 Reset values: rst_n low -> state IDLE, ptr_q 0, mem_rdata 0, timeout counter 0, mem_err 0, dmem_cyc/stb/we 0 within the same cycle.
REQ-021 Reset mid-access abandons the transaction; no late resp is accepted after release until a new request issues.

Configuration
REQ-022 Macro MEM_TIMEOUT_EN.
- Defined: counter counts cycles in PTR/DATA without resp. On reaching TIMEOUT_CYC -> mem_err pulses 1 cycle, state IDLE, mem_stall drops, mem_rdata unchanged.
- Undefined: no counter; the FSM waits indefinitely; mem_err tied 0.

Structure
REQ-023 Package lc3b_types holds the FSM state enum (mem_state_t) and the byte-lane helper width constant; opcodes remain in lc3b_types.
REQ-024 Lane decoding (sel/wdata replication) is sub-module mem_lane_steer; the FSM and registers stay in mem_access_ctrl.

Verification
REQ-025 LDR, alu_out=0x3000, resp after 2 waits, rdata=0xBEEF -> 3 stall cycles; mem_rdata=0xBEEF next cycle; we=0.
REQ-026 STB, alu_out=0x3001, dest_out=0x12AB -> sel=2'b10, wdata=0xABAB, we=1, single request.
REQ-027 LDI, alu_out=0x4000; pointer read returns 0x5000, final read returns 0x00C3 -> two requests: addr 0x4000 then 0x5000; mem_rdata=0x00C3; stall continuous until second resp.
REQ-028 STI, pointer=0x6002 -> first request we=0, second request addr=0x6002 with we=1, sel=2'b11.
REQ-029 Reset mid-PTR: rst_n low with a pending request -> cyc/stb/we 0 immediately; later stray resp ignored; state IDLE.
REQ-030 MEM_TIMEOUT_EN with TIMEOUT_CYC=4, no resp -> mem_err high for exactly one cycle after 4 wait cycles; stall drops; state IDLE.
